// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg: opcodes, in_op and FSM state enums, and field-packing helpers for inst_encoder
package inst_enc_pkg;
  typedef enum logic [2:0] {
    OP_ADD,
    OP_ADDI,
    OP_LD,
    OP_ST,
    OP_LU12I,
    OP_BNE,
    OP_LI,
    OP_NOP
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_ONE,
    S_HI
  } state_t;
  localparam logic [16:0] OPC_ADD = 17'h00020;
  localparam logic [9:0] OPC_ADDI = 10'b0000001010;
  localparam logic [9:0] OPC_LD = 10'b0010100010;
  localparam logic [9:0] OPC_ST = 10'b0010100110;
  localparam logic [6:0] OPC_LU12I = 7'b0001010;
  localparam logic [5:0] OPC_BNE = 6'b010111;
  localparam logic [31:0] NOP_WORD = 32'h0280_0000;
  function automatic logic fits_s12(input logic [31:0] v);
    return &v[31:11] | ~|v[31:11];
  endfunction
  function automatic logic [31:0] enc_ri12(input logic [9:0] opc, input logic [11:0] si12,
                                           input logic [4:0] rj, input logic [4:0] rd);
    return {opc, si12, rj, rd};
  endfunction
  function automatic logic [31:0] enc_lu12i(input logic [19:0] si20, input logic [4:0] rd);
    return {OPC_LU12I, si20, rd};
  endfunction
endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request and instruction-word handshake bundle for inst_encoder
interface inst_encoder_if;
  import inst_enc_pkg::*;
  logic in_valid;
  logic in_ready;
  op_t in_op;
  logic [4:0] in_rd;
  logic [4:0] in_rj;
  logic [4:0] in_rk;
  logic [31:0] in_imm;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic err;
  modport master(
    output in_valid, in_op, in_rd, in_rj, in_rk, in_imm, out_ready,
    input in_ready, out_valid, out_inst, out_addr, err
  );
  modport slave(
    input in_valid, in_op, in_rd, in_rj, in_rk, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, err
  );
endinterface

// File: rtl/inst_field_pack.sv
// inst_field_pack: combinational LoongArch32 field packer with range check; LI_SHORT_EN selects single-word LI
module inst_field_pack
  import inst_enc_pkg::*;
(
  input  op_t         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rj,
  input  logic [4:0]  rk,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);
  logic [19:0] hi20;
  logic s12;
  logic s18;
  assign hi20 = imm[31:12] + {19'd0, imm[11]};
  assign s12 = fits_s12(imm);
  assign s18 = &imm[31:17] | ~|imm[31:17];
  // map one request to its first (or only) instruction word and flag out-of-range immediates
  always_comb begin
    word = NOP_WORD;
    range_err = 1'b0;
    case (op)
      OP_ADD: word = {OPC_ADD, rk, rj, rd};
      OP_ADDI: begin
        word = enc_ri12(OPC_ADDI, imm[11:0], rj, rd);
        range_err = !s12;
      end
      OP_LD: begin
        word = enc_ri12(OPC_LD, imm[11:0], rj, rd);
        range_err = !s12;
      end
      OP_ST: begin
        word = enc_ri12(OPC_ST, imm[11:0], rj, rd);
        range_err = !s12;
      end
      OP_LU12I: word = enc_lu12i(imm[19:0], rd);
      OP_BNE: begin
        word = {OPC_BNE, imm[17:2], rj, rd};
        range_err = |imm[1:0] | !s18;
      end
`ifdef LI_SHORT_EN
      OP_LI: word = s12 ? enc_ri12(OPC_ADDI, imm[11:0], 5'd0, rd) : enc_lu12i(hi20, rd);
`else
      OP_LI: word = enc_lu12i(hi20, rd);
`endif
      default: word = NOP_WORD;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: handshake instruction encoder with LI expansion and address counter; LI_SHORT_EN enables single-word LI
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  inst_encoder_if.slave bus
);
  state_t state;
  logic [31:0] word;
  logic [31:0] pend;
  logic f_err;
  logic acc;
  logic xfer;
  logic two;
  inst_field_pack u_pack (
    .op(bus.in_op),
    .rd(bus.in_rd),
    .rj(bus.in_rj),
    .rk(bus.in_rk),
    .imm(bus.in_imm),
    .word(word),
    .range_err(f_err)
  );
  assign bus.in_ready = state == S_IDLE || (state == S_ONE && bus.out_ready);
  assign bus.out_valid = state != S_IDLE;
  assign acc = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;
`ifdef LI_SHORT_EN
  // a zero low half already makes the LU12I.W word exact, so it stands alone
  assign two = bus.in_op == OP_LI && !fits_s12(bus.in_imm) && |bus.in_imm[11:0];
`else
  assign two = bus.in_op == OP_LI;
`endif
  // output word register, LI tail holding, address counter and error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      bus.out_inst <= 32'd0;
      bus.out_addr <= BASE_ADDR;
      bus.err <= 1'b0;
      pend <= 32'd0;
    end else begin
      bus.err <= acc && f_err;
      if (xfer) bus.out_addr <= bus.out_addr + 32'd4;
      if (acc && !f_err) begin
        state <= two ? S_HI : S_ONE;
        bus.out_inst <= word;
        pend <= enc_ri12(OPC_ADDI, bus.in_imm[11:0], bus.in_rd, bus.in_rd);
      end else if (xfer) begin
        state <= state == S_HI ? S_ONE : S_IDLE;
        if (state == S_HI) bus.out_inst <= pend;
      end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder against an arithmetic queue model
module tb_inst_encoder;
  import inst_enc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  inst_encoder_if bus ();
  inst_encoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] q[$];
  logic [31:0] addr_m;
  logic err_exp;
  logic [31:0] bnd[10];
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ri(input longint opc, input longint si, input longint rj,
                                     input longint rd);
    return 32'(opc * 4194304 + (si & 4095) * 1024 + rj * 32 + rd);
  endfunction
  function automatic logic [31:0] lu(input longint hi, input longint rd);
    return 32'(10 * 33554432 + (hi & 'hFFFFF) * 32 + rd);
  endfunction
  function automatic void model(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rj,
                                input logic [4:0] rk, input logic [31:0] imm);
    int s;
    longint u;
    longint opc;
    s = $signed(imm);
    u = longint'(imm);
    opc = op == 1 ? 10 : op == 2 ? 162 : 166;
    case (op)
      0: q.push_back(32'(1048576 + longint'(rk) * 1024 + longint'(rj) * 32 + longint'(rd)));
      1, 2, 3:
        if (s < -2048 || s > 2047) err_exp = 1'b1;
        else q.push_back(ri(opc, s, rj, rd));
      4: q.push_back(lu(u % 1048576, rd));
      5:
        if (s % 4 != 0 || s < -131072 || s > 131068) err_exp = 1'b1;
        else q.push_back(32'(23 * 67108864 + (longint'(s / 4) & 65535) * 1024
                             + longint'(rj) * 32 + longint'(rd)));
      6: begin
`ifdef LI_SHORT_EN
        if (s >= -2048 && s <= 2047) q.push_back(ri(10, s, 0, rd));
        else if (u % 4096 == 0) q.push_back(lu(u / 4096, rd));
        else begin
          q.push_back(lu((u + 2048) / 4096, rd));
          q.push_back(ri(10, u % 4096, rd, rd));
        end
`else
        q.push_back(lu((u + 2048) / 4096, rd));
        q.push_back(ri(10, u % 4096, rd, rd));
`endif
      end
      default: q.push_back(32'h0280_0000);
    endcase
  endfunction
  task automatic step(input logic v, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rj, input logic [4:0] rk, input logic [31:0] imm,
                      input logic ordy);
    logic rdy;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_op = op_t'(op);
    bus.in_rd = rd;
    bus.in_rj = rj;
    bus.in_rk = rk;
    bus.in_imm = imm;
    bus.out_ready = ordy;
    #1;
    check("err", 32'(bus.err), 32'(err_exp));
    err_exp = 1'b0;
    rdy = q.size() == 0 || (q.size() == 1 && ordy);
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_inst", bus.out_inst, q[0]);
      check("out_addr", bus.out_addr, addr_m);
    end
    if (q.size() != 0 && ordy) begin
      void'(q.pop_front());
      addr_m += 32'd4;
    end
    if (v && rdy) model(op, rd, rj, rk, imm);
  endtask
  task automatic idle(input logic ordy);
    step(1'b0, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, ordy);
  endtask
  task automatic lit(input string tag, input logic [31:0] inst, input logic [31:0] addr);
    @(posedge clk);
    #1;
    check(tag, bus.out_inst, inst);
    check({tag, "_addr"}, bus.out_addr, addr);
  endtask
  initial begin
    bnd = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'h1FFFC, 32'h20000,
            32'hFFFE0000, 32'hFFFDFFFC, 32'd6, 32'd0};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = OP_NOP;
    bus.in_rd = 5'd0;
    bus.in_rj = 5'd0;
    bus.in_rk = 5'd0;
    bus.in_imm = 32'd0;
    bus.out_ready = 1'b0;
    addr_m = 32'd0;
    err_exp = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_inst", bus.out_inst, 32'd0);
    check("rst_addr", bus.out_addr, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    lit("add", 32'h001018A4, 32'd0);
    idle(1'b1);
    step(1'b1, 3'd6, 5'd1, 5'd0, 5'd0, 32'h12345FFF, 1'b0);
    lit("li_hi", 32'h142468C1, 32'd4);
    repeat (3) idle(1'b0);
    idle(1'b1);
    lit("li_lo", 32'h02BFFC21, 32'd8);
    idle(1'b1);
    step(1'b1, 3'd5, 5'd3, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b1);
    lit("bne", 32'h5FFFF843, 32'd12);
    idle(1'b1);
    step(1'b1, 3'd5, 5'd3, 5'd2, 5'd0, 32'd6, 1'b1);
    idle(1'b1);
    check("bne_err_addr", bus.out_addr, 32'd16);
    step(1'b1, 3'd1, 5'd3, 5'd2, 5'd0, 32'd2048, 1'b1);
    idle(1'b1);
    check("addi_err_addr", bus.out_addr, 32'd16);
    step(1'b1, 3'd6, 5'd2, 5'd0, 5'd0, 32'd5, 1'b0);
`ifdef LI_SHORT_EN
    lit("li5", 32'h02801402, 32'd16);
    idle(1'b1);
`else
    lit("li5_hi", 32'h14000002, 32'd16);
    idle(1'b1);
    lit("li5_lo", 32'h02801442, 32'd20);
    idle(1'b1);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 5'(i + 1), 5'd7, 5'd0, 32'(i * 3), 1'b1);
    repeat (2) idle(1'b1);
    step(1'b1, 3'd6, 5'd1, 5'd0, 5'd0, 32'h12345FFF, 1'b0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_addr", bus.out_addr, 32'd0);
    check("mid_rst_inst", bus.out_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    addr_m = 32'd0;
    err_exp = 1'b0;
    repeat (3) idle(1'b1);
    for (int i = 0; i < 1500; i++) begin
      automatic int k = $urandom_range(0, 3);
      automatic logic [31:0] im;
      im = k == 0 ? $urandom : k == 1 ? ($urandom & 32'h1FFF) - 32'h1000 :
           k == 2 ? bnd[$urandom_range(0, 9)] : $urandom & 32'hFFFFF000;
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
           5'($urandom), im, $urandom_range(0, 3) != 0);
    end
    repeat (4) idle(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
